// File: rtl/common_pkg.sv
// Helpers shared by sync_fifo and its read-side adapters: width function and default read geometry.
package common_pkg;

  localparam int DEF_RD_LAT    = 1;
  localparam int DEF_BUF_DEPTH = 3;

  // Bits needed to index n entries; never less than 1 so degenerate sizes still elaborate.
  function automatic int bw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of fifo_rd_stream; master = adapter side.
interface fifo_rd_stream_if
  import common_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_W-1:0]     fifo_rd_data;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [bw(BUF_DEPTH):0] occupancy;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last, occupancy
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last, occupancy
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Circular skid buffer with a registered head word; write and pop may share an edge.
// Caller guarantees no write when full (slots are reserved at issue time).
module stream_skid_buf
  import common_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid
);

  localparam int PTR_W = bw(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop = rd_en && head_valid;

  always_comb begin
    rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
    count_nxt  = count + CNT_W'(wr_en) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      // The arriving word becomes the head when it lands exactly where the read pointer will point.
      if (wr_en && (wr_ptr == rd_ptr_nxt)) head_data <= wr_data;
      else                                 head_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a fixed-latency FIFO read port into a valid/ready stream; out_valid RD_LAT+1 clks after a pop.
// Pops only when a buffer slot is reserved, so stalls never drop words. Optional: FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream
  import common_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int PKT_LEN   = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_rd_stream_if.master bus
);

  localparam int OCC_W = bw(BUF_DEPTH) + 1;

  if (RD_LAT < 1 || RD_LAT > 2 || BUF_DEPTH < RD_LAT + 1 || PKT_LEN < 1) begin : g_bad_cfg
    $error("fifo_rd_stream: unsupported RD_LAT/BUF_DEPTH/PKT_LEN combination");
  end

  logic              issue;
  logic              xfer;
  logic [RD_LAT-1:0] inflight;
  logic [OCC_W-1:0]  occ;

  // Occupancy counts in-flight words too, which is what makes the pop safe without looking at out_ready.
  assign issue          = rst && !bus.fifo_empty && (occ < OCC_W'(BUF_DEPTH));
  assign bus.fifo_rd_en = issue;
  assign xfer           = bus.out_valid && bus.out_ready;
  assign bus.occupancy  = occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      occ      <= '0;
    end else begin
      inflight <= (inflight << 1) | RD_LAT'(issue);
      occ      <= occ + OCC_W'(issue) - OCC_W'(xfer);
    end
  end

  stream_skid_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (inflight[RD_LAT-1]),
    .wr_data    (bus.fifo_rd_data),
    .rd_en      (bus.out_ready),
    .head_data  (bus.out_data),
    .head_valid (bus.out_valid)
  );

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int BCNT_W = bw(PKT_LEN);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(PKT_LEN - 1);

  logic [BCNT_W-1:0] beat_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      beat_cnt <= '0;
    else if (xfer) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BCNT_W'(1);
  end

  assign bus.out_last = bus.out_valid && (beat_cnt == LAST_BEAT);
`else
  assign bus.out_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream (RD_LAT=1, BUF_DEPTH=3, PKT_LEN=4) with a behavioural upstream FIFO and scoreboard.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

  localparam int DATA_W    = 8;
  localparam int RD_LAT    = 1;
  localparam int BUF_DEPTH = 3;
  localparam int PKT_LEN   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) bus ();

  fifo_rd_stream #(
    .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [DATA_W-1:0] src_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] w;
  logic rd_en_s;
  bit   starve = 1'b0;
  bit   gate   = 1'b0;

  // Upstream FIFO model: pop seen before the edge, data and registered empty updated just after it.
  initial begin
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    forever begin
      @(negedge clk);
      rd_en_s = bus.fifo_rd_en;
      @(posedge clk);
      #1;
      if (!rst) begin
        exp_q.delete();
      end else if (rd_en_s && src_q.size() > 0) begin
        w = src_q.pop_front();
        bus.fifo_rd_data = w;
        exp_q.push_back(w);
        pops++;
      end
      gate = ~gate;
      bus.fifo_empty = (src_q.size() == 0) || (starve && gate);
    end
  end

  task automatic test_reset();
    int beats = 0;
    logic [DATA_W-1:0] e;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hA0 + i));
    repeat (3) @(negedge clk);
    checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL reset_setup_empty: got %b want 0", bus.fifo_empty); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", bus.out_data); end
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL reset_release_rd_en: got %b want 1", bus.fifo_rd_en); end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL reset_drain_extra: got %0h want no beat", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin errors++; $display("FAIL reset_drain_data: got %0h want %0h", bus.out_data, e); end
        end
        beats++;
      end
      @(posedge clk); #2;
    end
    checks++; if (beats != 4) begin errors++; $display("FAIL reset_drain_count: got %0d want 4", beats); end
  endtask

  task automatic test_streaming();
    int beats = 0, bubbles = 0, t_issue = -1, t_valid = -1;
    logic [DATA_W-1:0] e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) src_q.push_back(8'(i));
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (t_issue < 0 && bus.fifo_rd_en) t_issue = c;
      if (t_valid < 0 && bus.out_valid) t_valid = c;
      if (beats > 0 && beats < 64 && !bus.out_valid) bubbles++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stream_extra: got %0h want no beat", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e || e !== 8'(beats)) begin
            errors++; $display("FAIL stream_data: got %0h want %0h", bus.out_data, 8'(beats));
          end
        end
        beats++;
      end
      @(posedge clk); #2;
    end
    checks++; if (beats != 64) begin errors++; $display("FAIL stream_count: got %0d want 64", beats); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
    checks++; if (t_valid - t_issue != RD_LAT + 1) begin errors++; $display("FAIL stream_latency: got %0d want %0d", t_valid - t_issue, RD_LAT + 1); end
  endtask

  task automatic test_stall();
    int beats = 0, pops0;
    logic [DATA_W-1:0] e;
    bus.out_ready = 1'b0;
    pops0 = pops;
    for (int i = 0; i < 20; i++) src_q.push_back(8'(100 + i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== 8'd100) begin errors++; $display("FAIL stall_hold: got %0h want %0h", bus.out_data, 8'd100); end
      end
      @(posedge clk); #2;
    end
    @(negedge clk);
    checks++; if (pops - pops0 != BUF_DEPTH) begin errors++; $display("FAIL stall_pops: got %0d want %0d", pops - pops0, BUF_DEPTH); end
    checks++; if (bus.occupancy !== 3'(BUF_DEPTH)) begin errors++; $display("FAIL stall_occupancy: got %0d want %0d", bus.occupancy, BUF_DEPTH); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en: got %b want 0", bus.fifo_rd_en); end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall_extra: got %0h want no beat", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e || e !== 8'(100 + beats)) begin
            errors++; $display("FAIL stall_data: got %0h want %0h", bus.out_data, 8'(100 + beats));
          end
        end
        beats++;
      end
      @(posedge clk); #2;
    end
    checks++; if (beats != 20) begin errors++; $display("FAIL stall_count: got %0d want 20", beats); end
  endtask

  task automatic test_starve();
    int beats = 0, pops0;
    logic [DATA_W-1:0] e;
    starve = 1'b1;
    bus.out_ready = 1'b1;
    pops0 = pops;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(200 + i));
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL starve_duplicate: got %0h want no beat", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin errors++; $display("FAIL starve_data: got %0h want %0h", bus.out_data, e); end
        end
        beats++;
      end
      @(posedge clk); #2;
    end
    starve = 1'b0;
    checks++; if (beats != 16) begin errors++; $display("FAIL starve_count: got %0d want 16", beats); end
    checks++; if (pops - pops0 != beats) begin errors++; $display("FAIL starve_pop_beat: got %0d pops want %0d", pops - pops0, beats); end
  endtask

  task automatic test_reset_midflight();
    int beats = 0;
    bit found = 1'b0;
    logic [DATA_W-1:0] e;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h30 + i));
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.occupancy == 3'd2) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midflight_reach_occ2: got timeout want occupancy 2"); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midflight_buffered: got %b want 1", bus.out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus.occupancy !== '0) begin errors++; $display("FAIL midflight_occupancy: got %0d want 0", bus.occupancy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midflight_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midflight_rd_en: got %b want 0", bus.fifo_rd_en); end
    src_q.delete();
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 6; i++) src_q.push_back(8'(8'h55 + i));
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL midflight_extra: got %0h want no beat", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e || e !== 8'(8'h55 + beats)) begin
            errors++; $display("FAIL midflight_data: got %0h want %0h", bus.out_data, 8'(8'h55 + beats));
          end
        end
        beats++;
      end
      @(posedge clk); #2;
    end
    checks++; if (beats != 6) begin errors++; $display("FAIL midflight_count: got %0d want 6", beats); end
  endtask

  task automatic test_last();
    int beats = 0, lasts = 0, want_lasts;
    logic want_last;
    logic [DATA_W-1:0] e;
`ifdef FIFO_RD_STREAM_LAST_EN
    want_lasts = 3;
`else
    want_lasts = 0;
`endif
    bus.out_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) src_q.push_back(8'(8'hC0 + i));
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.out_valid && bus.out_last !== 1'b0) begin
        checks++; errors++; $display("FAIL last_without_valid: got %b want 0", bus.out_last);
      end
      if (bus.out_valid && bus.out_ready) begin
`ifdef FIFO_RD_STREAM_LAST_EN
        want_last = ((beats % PKT_LEN) == PKT_LEN - 1);
`else
        want_last = 1'b0;
`endif
        checks++;
        if (bus.out_last !== want_last) begin errors++; $display("FAIL last_flag: beat %0d got %b want %b", beats, bus.out_last, want_last); end
        if (bus.out_last === 1'b1) lasts++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL last_extra: got %0h want no beat", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin errors++; $display("FAIL last_data: got %0h want %0h", bus.out_data, e); end
        end
        beats++;
      end
      @(posedge clk); #2;
      bus.out_ready = (c >= 70) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    checks++; if (beats != 12) begin errors++; $display("FAIL last_count: got %0d want 12", beats); end
    checks++; if (lasts != want_lasts) begin errors++; $display("FAIL last_total: got %0d want %0d", lasts, want_lasts); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_starve();
    test_reset_midflight();
    test_last();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
